// File: rtl/bus_encode.sv
// Serializes wide words from a small FIFO into little-endian low-width beats,
// handshaking each beat with a start pulse / finish pulse transmitter.
module bus_encode #(
  parameter  int BRUST_SIZE_LOG  = 2,
  parameter  int LOW_DATA_WIDTH  = 8,
  parameter  int FIFO_DEPTH_LOG  = 1,
  localparam int HIGH_DATA_WIDTH = LOW_DATA_WIDTH << BRUST_SIZE_LOG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [HIGH_DATA_WIDTH-1:0] high_write_data,
  input  logic                       high_write_valid,
  output logic                       high_write_ready,
  output logic                       low_write_valid,
  output logic [LOW_DATA_WIDTH-1:0]  low_write_data,
  input  logic                       low_write_finish,
  output logic                       busy
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0]   DEPTH_COUNT = (FIFO_DEPTH_LOG + 1)'(FIFO_DEPTH);
  localparam logic [BRUST_SIZE_LOG-1:0] LAST_BEAT   = '1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                      state_q, state_d;
  logic [HIGH_DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [HIGH_DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG:0]     count_q, count_d;
  logic [HIGH_DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [BRUST_SIZE_LOG-1:0]   beat_q, beat_d;
  logic                        valid_q, valid_d;
  logic [LOW_DATA_WIDTH-1:0]   data_q, data_d;
  logic                        push;
  logic                        pop;

  // Ready looks only at the stored count, so a full buffer refuses a push
  // even on the cycle the serializer pops.
  assign high_write_ready = (count_q < DEPTH_COUNT);
  assign push             = high_write_valid && high_write_ready;
  assign low_write_valid  = valid_q;
  assign low_write_data   = data_q;
  assign busy             = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    valid_d = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          beat_d  = '0;
          state_d = START;
          valid_d = 1'b1;
          data_d  = mem_q[rd_ptr_q][LOW_DATA_WIDTH-1:0];
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (low_write_finish) begin
          if (beat_q != LAST_BEAT) begin
            shift_d = shift_q >> LOW_DATA_WIDTH;
            beat_d  = beat_q + 1'b1;
            state_d = START;
            valid_d = 1'b1;
            data_d  = shift_d[LOW_DATA_WIDTH-1:0];
          end else if (count_q != '0) begin
            // Chain straight into the next word so back-to-back words have no gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            beat_d  = '0;
            state_d = START;
            valid_d = 1'b1;
            data_d  = mem_q[rd_ptr_q][LOW_DATA_WIDTH-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = high_write_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

endmodule
